// File: rtl/parity_serial_tx.sv
// parity_serial_tx
//
// Serialises a DATA_W-bit word as an idle-high frame:
//   start (0), DATA_W data bits LSB first, parity bit, stop bit(s) (1).
// Each frame bit is held on tx for CLKS_PER_BIT clock cycles.
//
// Parameters:
//   DATA_W        data word width in bits (>= 1)
//   CLKS_PER_BIT  clock cycles per frame bit (>= 1)
//   ODD_PARITY    0: parity = ^din, 1: parity = ~^din
//
// Build option:
//   PARITY_TX_STOP2_EN  when defined, two stop bits are sent
//                       (STOP lasts 2*CLKS_PER_BIT cycles).
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   din         word to transmit, sampled on acceptance
//   din_valid   upstream presents a word on din
//   din_ready   block can accept (IDLE and rst low)
//   tx          registered serial line, idle high
//   busy        high from the cycle after acceptance through the last stop cycle
//   parity_bit  registered parity of the last accepted word
//   frame_done  one-cycle pulse in the final cycle of the stop period

module parity_serial_tx #(
    parameter int unsigned DATA_W       = 9,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          ODD_PARITY   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              busy,
    output logic              parity_bit,
    output logic              frame_done
);

`ifdef PARITY_TX_STOP2_EN
    localparam int unsigned StopBits = 2;
`else
    localparam int unsigned StopBits = 1;
`endif

    localparam int unsigned StopClks = StopBits * CLKS_PER_BIT;

    // The clock counter must span the longest state (STOP may be two bits long).
    localparam int unsigned ClkCntW = $clog2(StopClks) + 1;
    localparam int unsigned BitCntW = $clog2(DATA_W) + 1;

    localparam logic [ClkCntW-1:0] BitClkLast  = ClkCntW'(CLKS_PER_BIT - 1);
    localparam logic [ClkCntW-1:0] StopClkLast = ClkCntW'(StopClks - 1);
    localparam logic [BitCntW-1:0] DataBitLast = BitCntW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [ClkCntW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                tx_q, tx_d;
    logic                accept;

    // Ready is gated by rst so that a word presented during reset is never taken.
    assign din_ready = (state_q == StIdle) && !rst;
    assign accept    = din_valid && din_ready;

    // Next-state, counter and datapath logic.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (accept) begin
                    state_d  = StStart;
                    shift_d  = din;
                    parity_d = (^din) ^ ODD_PARITY;
                end
            end

            StStart: begin
                if (clk_cnt_q == BitClkLast) begin
                    state_d   = StData;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end

            StData: begin
                if (clk_cnt_q == BitClkLast) begin
                    clk_cnt_d = '0;
                    // Shift at the bit boundary so shift_q[0] is always the bit on the line.
                    shift_d   = shift_q >> 1;
                    if (bit_cnt_q == DataBitLast) begin
                        state_d   = StParity;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            StParity: begin
                if (clk_cnt_q == BitClkLast) begin
                    state_d   = StStop;
                    clk_cnt_d = '0;
                end
            end

            StStop: begin
                if (clk_cnt_q == StopClkLast) begin
                    state_d   = StIdle;
                    clk_cnt_d = '0;
                end
            end

            default: begin
                state_d   = StIdle;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // tx is registered from the next state so the line only moves at bit
    // boundaries and the start bit appears the cycle after acceptance.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign parity_bit = parity_q;
    assign busy       = (state_q != StIdle);
    // Decoded from registered state only, so it cannot glitch.
    assign frame_done = (state_q == StStop) && (clk_cnt_q == StopClkLast);

endmodule

// File: tb/tb_parity_serial_tx.sv
// Testbench for parity_serial_tx.
// Two instances run side by side: unit 0 uses the defaults (even parity,
// 4 clocks per bit); unit 1 uses odd parity with 1 clock per bit.
// Expected frames come from a bit-list model of the frame format.

module tb_parity_serial_tx;

    localparam int DW = 9;

`ifdef PARITY_TX_STOP2_EN
    localparam int StopBits = 2;
`else
    localparam int StopBits = 1;
`endif

    logic          clk;
    logic          rst        [2];
    logic [DW-1:0] din        [2];
    logic          din_valid  [2];
    logic          din_ready  [2];
    logic          tx         [2];
    logic          busy       [2];
    logic          parity_bit [2];
    logic          frame_done [2];

    int checks;
    int errors;
    bit exp_q[$];

    parity_serial_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(4),
        .ODD_PARITY  (1'b0)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst[0]),
        .din       (din[0]),
        .din_valid (din_valid[0]),
        .din_ready (din_ready[0]),
        .tx        (tx[0]),
        .busy      (busy[0]),
        .parity_bit(parity_bit[0]),
        .frame_done(frame_done[0])
    );

    parity_serial_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(1),
        .ODD_PARITY  (1'b1)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst[1]),
        .din       (din[1]),
        .din_valid (din_valid[1]),
        .din_ready (din_ready[1]),
        .tx        (tx[1]),
        .busy      (busy[1]),
        .parity_bit(parity_bit[1]),
        .frame_done(frame_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb(input int idx);
        return (idx == 0) ? 4 : 1;
    endfunction

    function automatic bit ref_parity(input int idx, input logic [DW-1:0] w);
        bit odd_ones;
        odd_ones = (($countones(w) % 2) == 1);
        return (idx == 1) ? !odd_ones : odd_ones;
    endfunction

    // Expected tx value for every cycle of the frame, starting the cycle after acceptance.
    task automatic build_frame(input int idx, input logic [DW-1:0] w, input bit p);
        exp_q.delete();
        repeat (cpb(idx)) exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            repeat (cpb(idx)) exp_q.push_back(w[i]);
        end
        repeat (cpb(idx)) exp_q.push_back(p);
        repeat (cpb(idx) * StopBits) exp_q.push_back(1'b1);
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle. With chain set, din_valid stays
    // high through the frame so the next call is accepted in the single idle cycle.
    task automatic frame(input int idx, input logic [DW-1:0] w, input bit chain);
        bit p;
        int n;
        p = ref_parity(idx, w);
        build_frame(idx, w, p);
        n = exp_q.size();
        check_val($sformatf("u%0d ready_pre", idx), 32'(din_ready[idx]), 32'd1);
        din[idx]       = w;
        din_valid[idx] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            check_val($sformatf("u%0d w%0h tx k%0d", idx, w, k), 32'(tx[idx]), 32'(exp_q[k]));
            check_val($sformatf("u%0d busy k%0d", idx, k), 32'(busy[idx]), 32'd1);
            check_val($sformatf("u%0d ready k%0d", idx, k), 32'(din_ready[idx]), 32'd0);
            check_val($sformatf("u%0d done k%0d", idx, k), 32'(frame_done[idx]),
                      32'(k == n - 1));
            if (k == 0) begin
                check_val($sformatf("u%0d w%0h parity", idx, w), 32'(parity_bit[idx]), 32'(p));
            end
            // Junk on din while busy must never be taken.
            din[idx]       = DW'($urandom);
            din_valid[idx] = chain || ((k < n - 1) && ($urandom_range(0, 1) == 1));
            @(negedge clk);
        end
        check_val($sformatf("u%0d idle tx", idx), 32'(tx[idx]), 32'd1);
        check_val($sformatf("u%0d idle busy", idx), 32'(busy[idx]), 32'd0);
        check_val($sformatf("u%0d idle done", idx), 32'(frame_done[idx]), 32'd0);
        check_val($sformatf("u%0d idle ready", idx), 32'(din_ready[idx]), 32'd1);
        check_val($sformatf("u%0d idle parity", idx), 32'(parity_bit[idx]), 32'(p));
    endtask

    // Accept w, then pulse rst (with din_valid high) in the first cycle of data bit 4.
    task automatic abort_frame(input int idx, input logic [DW-1:0] w);
        int ab;
        ab = cpb(idx) * 5;
        build_frame(idx, w, ref_parity(idx, w));
        din[idx]       = w;
        din_valid[idx] = 1'b1;
        @(negedge clk);
        din_valid[idx] = 1'b0;
        for (int k = 0; k <= ab; k++) begin
            check_val($sformatf("u%0d abort tx k%0d", idx, k), 32'(tx[idx]), 32'(exp_q[k]));
            if (k < ab) @(negedge clk);
        end
        rst[idx]       = 1'b1;
        din_valid[idx] = 1'b1;
        din[idx]       = DW'($urandom);
        #1;
        check_val($sformatf("u%0d ready_in_rst", idx), 32'(din_ready[idx]), 32'd0);
        @(negedge clk);
        check_val($sformatf("u%0d rst tx", idx), 32'(tx[idx]), 32'd1);
        check_val($sformatf("u%0d rst busy", idx), 32'(busy[idx]), 32'd0);
        check_val($sformatf("u%0d rst done", idx), 32'(frame_done[idx]), 32'd0);
        check_val($sformatf("u%0d rst parity", idx), 32'(parity_bit[idx]), 32'd0);
        rst[idx]       = 1'b0;
        din_valid[idx] = 1'b0;
        #1;
        check_val($sformatf("u%0d ready_after_rst", idx), 32'(din_ready[idx]), 32'd1);
        // Line must stay idle with no replay of the aborted word.
        @(negedge clk);
        check_val($sformatf("u%0d post_rst tx", idx), 32'(tx[idx]), 32'd1);
        check_val($sformatf("u%0d post_rst busy", idx), 32'(busy[idx]), 32'd0);
    endtask

    task automatic random_run(input int idx, input int count);
        bit chain;
        for (int r = 0; r < count; r++) begin
            chain = (r < count - 1) && ($urandom_range(0, 1) == 1);
            frame(idx, DW'($urandom), chain);
            if (!chain) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    check_val($sformatf("u%0d gap tx", idx), 32'(tx[idx]), 32'd1);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 2; i++) begin
            rst[i]       = 1'b1;
            din[i]       = '0;
            din_valid[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("u%0d reset tx", i), 32'(tx[i]), 32'd1);
            check_val($sformatf("u%0d reset busy", i), 32'(busy[i]), 32'd0);
            check_val($sformatf("u%0d reset parity", i), 32'(parity_bit[i]), 32'd0);
            check_val($sformatf("u%0d reset done", i), 32'(frame_done[i]), 32'd0);
            check_val($sformatf("u%0d reset ready", i), 32'(din_ready[i]), 32'd0);
            rst[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("u%0d ready_out_of_reset", i), 32'(din_ready[i]), 32'd1);
        end

        // Unit 0: even parity, 4 clocks per bit.
        frame(0, 9'h000, 1'b0);
        frame(0, 9'h1FF, 1'b1);
        frame(0, 9'h155, 1'b0);
        abort_frame(0, 9'h1C3);
        frame(0, 9'h0F0, 1'b0);
        random_run(0, 6);

        // Unit 1: odd parity, 1 clock per bit.
        frame(1, 9'h000, 1'b0);
        frame(1, 9'h003, 1'b1);
        frame(1, 9'h0A5, 1'b0);
        abort_frame(1, 9'h0A5);
        frame(1, 9'h13C, 1'b0);
        random_run(1, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
